// File: rtl/instr_register_pkg.sv
// Shared types for the instruction queue: opcode encoding, queue-entry
// layout and small opcode-class helpers.
// The entry operand width follows the INSTR_OP_W macro (default 32) so the
// entry struct can be resized for builds that change OP_W.
`ifndef INSTR_OP_W
`define INSTR_OP_W 32
`endif

package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    localparam int ENTRY_OP_W = `INSTR_OP_W;

    // One queue slot: instruction, operands and the result computed at push.
    // flags[0] = div_by_zero, flags[1] = saturated.
    typedef struct packed {
        opcode_t                   opcode;
        logic [ENTRY_OP_W-1:0]     a;
        logic [ENTRY_OP_W-1:0]     b;
        logic [2*ENTRY_OP_W-1:0]   result;
        logic [1:0]                flags;
    } queue_entry_t;

    // Opcodes whose divisor may be zero.
    function automatic logic is_div_op(opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

    // Opcodes whose result can leave the signed OP_W range.
    function automatic logic is_sat_op(opcode_t op);
        return (op == ADD) || (op == SUB) || (op == MULT);
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational result unit for the instruction queue.
// All arithmetic is signed at 2*OP_W after sign extension of both operands.
// DIV/MOD by zero yield 0 with div_by_zero set.
// Optional macro SATURATE_EN: clamp ADD/SUB/MULT results to the signed OP_W
// range and set the saturated flag.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  opcode_t             opcode,
    input  logic [OP_W-1:0]     operand_a,
    input  logic [OP_W-1:0]     operand_b,
    output logic [2*OP_W-1:0]   result,
    output logic [1:0]          flags
);

    localparam int RW = 2 * OP_W;

`ifdef SATURATE_EN
    localparam logic [RW-1:0] SAT_MAX = {{(OP_W+1){1'b0}}, {(OP_W-1){1'b1}}};
    localparam logic [RW-1:0] SAT_MIN = {{(OP_W+1){1'b1}}, {(OP_W-1){1'b0}}};
`endif

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] b_safe;
    logic signed [RW-1:0] raw;
    logic                 b_zero;
    logic                 div0;
    logic                 sat;

    // Compute the exact 2*OP_W result, then apply divide-by-zero and clamping rules.
    always_comb begin
        a_ext  = {{OP_W{operand_a[OP_W-1]}}, operand_a};
        b_ext  = {{OP_W{operand_b[OP_W-1]}}, operand_b};
        b_zero = (operand_b == '0);
        // Keep the divider operand defined when b is zero; that result is discarded.
        b_safe = b_ext;
        if (b_zero) begin
            b_safe = {{(RW-1){1'b0}}, 1'b1};
        end
        raw  = '0;
        sat  = 1'b0;
        case (opcode)
            ZERO:    raw = '0;
            PASSA:   raw = a_ext;
            PASSB:   raw = b_ext;
            ADD:     raw = a_ext + b_ext;
            SUB:     raw = a_ext - b_ext;
            MULT:    raw = a_ext * b_ext;
            DIV:     if (!b_zero) raw = a_ext / b_safe;
            MOD:     if (!b_zero) raw = a_ext % b_safe;
            default: raw = '0;
        endcase
        div0   = is_div_op(opcode) && b_zero;
        result = raw;
`ifdef SATURATE_EN
        // In range only when the top OP_W+1 bits are all copies of the sign.
        if (is_sat_op(opcode) && !((&raw[RW-1:OP_W-1]) || !(|raw[RW-1:OP_W-1]))) begin
            sat    = 1'b1;
            result = raw[RW-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        flags = {sat, div0};
    end

endmodule

// File: rtl/instr_queue_exec.sv
// Instruction queue with execute-at-push: each accepted instruction has its
// result computed by instr_alu and stored alongside it in a DEPTH-entry FIFO.
// Handshake: a transfer happens on a posedge where valid && ready; in_ready and
// out_valid depend only on the stored count, never on the opposite-side inputs.
// Optional macro SATURATE_EN (consumed by instr_alu) enables result clamping.
module instr_queue_exec
    import instr_register_pkg::*;
#(
    parameter int OP_W  = ENTRY_OP_W,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  opcode_t                   opcode,
    input  logic [OP_W-1:0]           operand_a,
    input  logic [OP_W-1:0]           operand_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output opcode_t                   out_opcode,
    output logic [OP_W-1:0]           out_a,
    output logic [OP_W-1:0]           out_b,
    output logic [2*OP_W-1:0]         out_result,
    output logic [1:0]                out_flags,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    queue_entry_t         mem_q [DEPTH];
    queue_entry_t         mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [2*OP_W-1:0]    alu_result;
    logic [1:0]           alu_flags;
    queue_entry_t         new_entry;
    queue_entry_t         head;
    logic                 push;
    logic                 pop;

    instr_alu #(.OP_W(OP_W)) u_alu (
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (alu_result),
        .flags     (alu_flags)
    );

    // Status and head-of-queue outputs, derived from stored state only.
    always_comb begin
        in_ready   = (count_q != CNT_W'(DEPTH));
        out_valid  = (count_q != '0);
        count      = count_q;
        head       = mem_q[rd_ptr_q];
        out_opcode = head.opcode;
        out_a      = head.a[OP_W-1:0];
        out_b      = head.b[OP_W-1:0];
        out_result = head.result[2*OP_W-1:0];
        out_flags  = head.flags;
    end

    // Next-state: write on push, advance pointers (natural power-of-two wrap), track occupancy.
    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;

        new_entry        = '0;
        new_entry.opcode = opcode;
        new_entry.a      = ENTRY_OP_W'(operand_a);
        new_entry.b      = ENTRY_OP_W'(operand_b);
        new_entry.result = (2*ENTRY_OP_W)'(alu_result);
        new_entry.flags  = alu_flags;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the queue and zeroes every slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_queue_exec.sv
// Bench for instr_queue_exec: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the instruction FIFO.
module tb_instr_queue_exec;
    import instr_register_pkg::*;

    localparam int OP_W  = 32;
    localparam int DEPTH = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = 3 + OP_W + OP_W + 2*OP_W + 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    // ---------------- clock / reset / DUT ----------------
    logic                clk       = 1'b0;
    logic                reset_n   = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    opcode_t             opcode    = ZERO;
    logic [OP_W-1:0]     operand_a = '0;
    logic [OP_W-1:0]     operand_b = '0;
    logic                in_ready;
    logic                out_valid;
    opcode_t             out_opcode;
    logic [OP_W-1:0]     out_a;
    logic [OP_W-1:0]     out_b;
    logic [2*OP_W-1:0]   out_result;
    logic [1:0]          out_flags;
    logic [CNT_W-1:0]    count;

    always #5 clk = ~clk;

    instr_queue_exec #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_result (out_result),
        .out_flags  (out_flags),
        .count      (count)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs;
    assign obs = {out_opcode, out_a, out_b, out_result, out_flags};

    // Expected entry {opcode, a, b, result, saturated, div_by_zero} from plain integer math.
    function automatic logic [EW-1:0] model_entry(opcode_t op, int a, int b);
        longint r;
        logic   dz;
        logic   sat;
        r   = 0;
        dz  = 1'b0;
        sat = 1'b0;
        case (op)
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = longint'(a) + longint'(b);
            SUB:   r = longint'(a) - longint'(b);
            MULT:  r = longint'(a) * longint'(b);
            DIV:   if (b == 0) dz = 1'b1; else r = longint'(a) / longint'(b);
            MOD:   if (b == 0) dz = 1'b1; else r = longint'(a) % longint'(b);
            default: r = 0;
        endcase
`ifdef SATURATE_EN
        if (op == ADD || op == SUB || op == MULT) begin
            if (r > MAXV) begin r = MAXV; sat = 1'b1; end
            else if (r < MINV) begin r = MINV; sat = 1'b1; end
        end
`endif
        return {op, a, b, r, sat, dz};
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 4))
            0:       return int'($urandom_range(0, 40)) - 20;
            1:       return int'($urandom);
            2:       return int'(32'h8000_0000);
            3:       return int'(32'h7fff_ffff);
            default: return 0;
        endcase
    endfunction

    function automatic opcode_t rand_opc();
        return opcode_t'(3'($urandom_range(0, 7)));
    endfunction

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs, clock it, and update the model by the handshake rules.
    task automatic drive(input logic iv, input opcode_t op, input int a, input int b, input logic ordy);
        int sz;
        in_valid  = iv;
        opcode    = op;
        operand_a = a;
        operand_b = b;
        out_ready = ordy;
        sz = exp_q.size();
        @(posedge clk); #1;
        if (ordy && sz != 0) void'(exp_q.pop_front());
        if (iv && sz != DEPTH) exp_q.push_back(model_entry(op, a, b));
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (obs !== '0) begin miscompares++; $display("FAIL reset_out_fields: got %h want 0", obs); end
        reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        drive(1'b1, ADD, 5, -7, 1'b0);
        idle();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid: got %0b want 1", out_valid); end
        vectors++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL add_result: got %h want -2", out_result); end
        vectors++; if (out_flags !== 2'b00) begin miscompares++; $display("FAIL add_flags: got %b want 00", out_flags); end
        vectors++; if (count !== CNT_W'(1)) begin miscompares++; $display("FAIL add_count: got %0d want 1", count); end
        vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL add_entry: got %h want %h", obs, exp_q[0]); end
        drive(1'b0, ZERO, 0, 0, 1'b1);
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_div_mod();
        longint     exp_r [3] = '{-3, -1, 0};
        logic [1:0] exp_f [3] = '{2'b00, 2'b00, 2'b01};
        drive(1'b1, DIV, -7, 2, 1'b0);
        drive(1'b1, MOD, -7, 2, 1'b0);
        drive(1'b1, DIV, 9, 0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_result !== 64'(exp_r[i])) begin miscompares++; $display("FAIL divmod_result[%0d]: got %h want %h", i, out_result, 64'(exp_r[i])); end
            vectors++; if (out_flags !== exp_f[i]) begin miscompares++; $display("FAIL divmod_flags[%0d]: got %b want %b", i, out_flags, exp_f[i]); end
            vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL divmod_entry[%0d]: got %h want %h", i, obs, exp_q[0]); end
            drive(1'b0, ZERO, 0, 0, 1'b1);
        end
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_opc(), i, rand_val(), 1'b0);
        idle();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %0b want 0", in_ready); end
        vectors++; if (count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
        drive(1'b1, ADD, 999, 1, 1'b0);
        idle();
        vectors++; if (count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL full_extra_count: got %0d want %0d", count, DEPTH); end
        vectors++; if (out_a !== '0) begin miscompares++; $display("FAIL full_head_hold: got %0d want 0", out_a); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (out_a !== OP_W'(i)) begin miscompares++; $display("FAIL full_order[%0d]: got a=%0d want %0d", i, out_a, i); end
            vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL full_entry[%0d]: got %h want %h", i, obs, exp_q[0]); end
            drive(1'b0, ZERO, 0, 0, 1'b1);
        end
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH/2; i++) drive(1'b1, rand_opc(), rand_val(), rand_val(), 1'b0);
        for (int i = 0; i < 3*DEPTH; i++) begin
            vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL b2b_entry[%0d]: got %h want %h", i, obs, exp_q[0]); end
            drive(1'b1, rand_opc(), rand_val(), rand_val(), 1'b1);
            vectors++; if (count !== CNT_W'(DEPTH/2)) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, DEPTH/2); end
        end
        idle();
        while (exp_q.size() > 0) begin
            vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL b2b_drain: got %h want %h", obs, exp_q[0]); end
            drive(1'b0, ZERO, 0, 0, 1'b1);
        end
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_mult_sat();
        drive(1'b1, MULT, 32'h4000_0000, 4, 1'b0);
        idle();
`ifdef SATURATE_EN
        vectors++; if (out_result !== 64'h0000_0000_7FFF_FFFF) begin miscompares++; $display("FAIL mult_result: got %h want 7fffffff", out_result); end
        vectors++; if (out_flags !== 2'b10) begin miscompares++; $display("FAIL mult_flags: got %b want 10", out_flags); end
`else
        vectors++; if (out_result !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL mult_result: got %h want 100000000", out_result); end
        vectors++; if (out_flags !== 2'b00) begin miscompares++; $display("FAIL mult_flags: got %b want 00", out_flags); end
`endif
        vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL mult_entry: got %h want %h", obs, exp_q[0]); end
        drive(1'b0, ZERO, 0, 0, 1'b1);
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, rand_opc(), rand_val(), rand_val(), 1'b0);
        idle();
        vectors++; if (count !== CNT_W'(5)) begin miscompares++; $display("FAIL midrst_pre_count: got %0d want 5", count); end
        #3 reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", count); end
        vectors++; if (obs !== '0) begin miscompares++; $display("FAIL midrst_fields: got %h want 0", obs); end
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1'b1, PASSB, 0, 12345, 1'b0);
        idle();
        vectors++; if (count !== CNT_W'(1)) begin miscompares++; $display("FAIL midrst_new_count: got %0d want 1", count); end
        vectors++; if (out_b !== OP_W'(12345)) begin miscompares++; $display("FAIL midrst_new_b: got %0d want 12345", out_b); end
        vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL midrst_new_entry: got %h want %h", obs, exp_q[0]); end
        drive(1'b0, ZERO, 0, 0, 1'b1);
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            vectors++; if (out_valid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rnd_out_valid[%0d]: got %0b want %0b", i, out_valid, exp_q.size() != 0); end
            vectors++; if (count !== CNT_W'(exp_q.size())) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, exp_q.size()); end
            if (exp_q.size() != 0) begin
                vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL rnd_entry[%0d]: got %h want %h", i, obs, exp_q[0]); end
            end
            drive($urandom_range(0, 3) != 0, rand_opc(), rand_val(),
                  ($urandom_range(0, 7) == 0) ? 0 : rand_val(), $urandom_range(0, 2) != 0);
        end
        idle();
        while (exp_q.size() > 0) begin
            vectors++; if (obs !== exp_q[0]) begin miscompares++; $display("FAIL rnd_drain: got %h want %h", obs, exp_q[0]); end
            drive(1'b0, ZERO, 0, 0, 1'b1);
        end
        idle();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_add();
        test_div_mod();
        test_full();
        test_back_to_back();
        test_mult_sat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
